mc_alu: RTL
===========

MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 Parameter N, default 8, operand/result width; legal N >= 4, power of two.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 A_in  input  N  operand A.
REQ-005 B_in  input  N  operand B; low log2(N) bits are the shift amount for SHL/SHR.
REQ-006 alu_op  input  4  opcode: 0 NOP, 1 ADD, 2 SUB, 3 INC, 4 DEC, 5 AND, 6 OR, 7 XOR, 8 ADC, 9 SBB, A SHL, B SHR, C MUL, D-F reserved.
REQ-007 in_valid  input  1  request valid.
REQ-008 in_ready  output  1  block can accept a request.
REQ-009 alu_out  output  N  registered result.
REQ-010 carry_out  output  1  registered carry/borrow flag.
REQ-011 zero_flag  output  1  registered, alu_out == 0.
REQ-012 neg_flag  output  1  registered, alu_out[N-1].
REQ-013 ovf_flag  output  1  registered signed-overflow flag.
REQ-014 out_valid  output  1  result and flags valid.
REQ-015 out_ready  input  1  consumer accepts result.

Function
REQ-016 FSM states IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE.
REQ-017 Accept occurs on an edge with in_valid && in_ready; operands and opcode SHALL be captured there and ignored thereafter.
REQ-018 Single-cycle ops (0-9, D-F): IDLE -> DONE on accept; out_valid high after the next edge (latency 1).
REQ-019 SHL/SHR: IDLE -> BUSY, one bit shifted per cycle, shamt cycles total; shamt 0 SHALL behave as latency 1 with alu_out = A.
REQ-020 MUL: IDLE -> BUSY, shift-add one bit per cycle, out_valid exactly N edges after accept.
REQ-021 DONE -> IDLE on edge with out_ready; result, flags and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-022 Arithmetic modulo 2^N; ADD/INC/ADC carry = bit N of sum; SUB/DEC/SBB carry = borrow (1 when minuend < subtrahend + borrow-in).
REQ-023 ADC adds stored carry_out; SBB subtracts stored carry_out; stored carry is the value from the last completed op.
REQ-024 ovf_flag = two's-complement overflow for ADD/SUB/INC/DEC/ADC/SBB; 0 for logic, NOP, shifts.
REQ-025 AND/OR/XOR/NOP: carry_out 0; NOP and reserved opcodes SHALL produce alu_out = A.
REQ-026 SHL/SHR: logical, zero-fill; carry_out = last bit shifted out (0 when shamt 0).
REQ-027 MUL: alu_out = low N bits of A*B (unsigned); carry_out = ovf_flag = (high N bits != 0).
REQ-028 zero_flag and neg_flag SHALL derive from the final alu_out for every op.
REQ-029 Flags and alu_out update only on the edge entering DONE; other edges leave them unchanged.
REQ-030 in_valid while not in IDLE SHALL be ignored (no queuing).

Reset
REQ-031 rst_n low SHALL immediately force IDLE, alu_out 0, all flags 0, out_valid 0, stored carry 0, and abort any BUSY operation.
REQ-032 After rst_n release, in_ready SHALL be 1 and first accept possible on the next edge.

Verification (N=8)
REQ-033 ADD A=0A B=05 -> alu_out 0F, carry 0, zero 0, ovf 0, out_valid one edge after accept.
REQ-034 SUB A=05 B=0A -> FB, carry 1, neg 1, ovf 0; then INC A=FF -> 00, carry 1, zero 1; then ADC A=01 B=01 -> 03, carry 0.
REQ-035 MUL A=0C B=0B -> 84, carry 0, neg 1, out_valid 8 edges after accept; MUL A=10 B=20 -> 00, carry 1, zero 1, ovf 1.
REQ-036 SHL A=81 B=01 -> 02, carry 1, latency 1; SHL A=01 B=07 -> 80, carry 0, latency 7; SHR A=80 B=00 -> 80, carry 0, latency 1.
REQ-037 Hold out_ready 0 for 3 cycles after ADD A=7F B=01 -> 80, ovf 1, neg 1 held stable, in_ready 0, new in_valid ignored; out_ready 1 -> IDLE next edge.
REQ-038 Assert rst_n low 3 cycles into MUL -> all outputs 0 asynchronously, out_valid never asserted for aborted op, in_ready 1 after release.

Source files
------------

// File: rtl/mc_alu.sv
`default_nettype none
// ============================================================================
// Module   : mc_alu
// Purpose  : Multi-cycle ALU with a valid/ready request port and a held,
//            valid/ready result port. Add/subtract/logic ops finish in one
//            edge. Shifts move one bit per edge. Multiply is shift-add, one
//            multiplier bit per edge.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1   clock, all state on rising edge
//   rst_n      in   1   asynchronous active-low reset
//   A_in       in   N   operand A
//   B_in       in   N   operand B (low log2(N) bits = shift amount)
//   alu_op     in   4   opcode
//   in_valid   in   1   request valid
//   in_ready   out  1   block idle, request can be accepted
//   alu_out    out  N   registered result
//   carry_out  out  1   carry / borrow / last bit shifted out / MUL high!=0
//   zero_flag  out  1   alu_out == 0
//   neg_flag   out  1   alu_out[N-1]
//   ovf_flag   out  1   signed overflow (arith) or MUL high!=0
//   out_valid  out  1   result and flags valid
//   out_ready  in   1   consumer takes the result
// ============================================================================
module mc_alu #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] A_in,
  input  logic [N-1:0] B_in,
  input  logic [3:0]   alu_op,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] alu_out,
  output logic         carry_out,
  output logic         zero_flag,
  output logic         neg_flag,
  output logic         ovf_flag,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int SW = $clog2(N);

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_INC = 4'h3;
  localparam logic [3:0] OP_DEC = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_ADC = 4'h8;
  localparam logic [3:0] OP_SBB = 4'h9;
  localparam logic [3:0] OP_SHL = 4'hA;
  localparam logic [3:0] OP_SHR = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Captured opcode and multi-cycle working registers
  logic [3:0]     op_q, op_d;
  logic [N-1:0]   sh_q, sh_d;          // shift working value
  logic [2*N-1:0] mcand_q, mcand_d;    // multiplicand, pre-shifted per step
  logic [N-1:0]   mplier_q, mplier_d;  // multiplier, consumed LSB first
  logic [2*N-1:0] acc_q, acc_d;        // partial product
  logic [SW-1:0]  cnt_q, cnt_d;        // steps still to run in BUSY

  // Architectural outputs; carry_q doubles as the stored carry for ADC/SBB
  logic [N-1:0]   alu_out_q;
  logic           carry_q;
  logic           zero_q;
  logic           neg_q;
  logic           ovf_q;

  // Result loading, asserted only on the edge that enters DONE
  logic           load_out;
  logic [N-1:0]   fin_res;
  logic           fin_c;
  logic           fin_v;

  // --------------------------------------------------------------------------
  // Single-cycle datapath (operates directly on the request inputs)
  // --------------------------------------------------------------------------
  logic           unit_b;
  logic [N-1:0]   opb;
  logic           cin;
  logic [N:0]     sum_w;
  logic [N:0]     dif_w;
  logic           ovf_add;
  logic           ovf_sub;
  logic [N-1:0]   sc_res;
  logic           sc_c;
  logic           sc_v;

  always_comb begin
    unit_b = (alu_op == OP_INC) || (alu_op == OP_DEC);
    opb    = unit_b ? {{(N-1){1'b0}}, 1'b1} : B_in;
    cin    = ((alu_op == OP_ADC) || (alu_op == OP_SBB)) ? carry_q : 1'b0;
    // One extra bit on top: carry for the sum, borrow for the difference
    // (the difference wraps negative, which sets bit N).
    sum_w  = {1'b0, A_in} + {1'b0, opb} + {{N{1'b0}}, cin};
    dif_w  = {1'b0, A_in} - {1'b0, opb} - {{N{1'b0}}, cin};
    // Sign-based overflow holds even with a carry/borrow-in of one.
    ovf_add = (A_in[N-1] == opb[N-1]) && (sum_w[N-1] != A_in[N-1]);
    ovf_sub = (A_in[N-1] != opb[N-1]) && (dif_w[N-1] != A_in[N-1]);
  end

  always_comb begin
    sc_res = A_in;  // NOP and reserved opcodes pass A through
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (alu_op)
      OP_ADD, OP_INC, OP_ADC: begin
        sc_res = sum_w[N-1:0];
        sc_c   = sum_w[N];
        sc_v   = ovf_add;
      end
      OP_SUB, OP_DEC, OP_SBB: begin
        sc_res = dif_w[N-1:0];
        sc_c   = dif_w[N];
        sc_v   = ovf_sub;
      end
      OP_AND: sc_res = A_in & B_in;
      OP_OR:  sc_res = A_in | B_in;
      OP_XOR: sc_res = A_in ^ B_in;
      default: begin
        sc_res = A_in;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Multi-cycle step logic. The accept edge performs the first step itself,
  // so an operation of k steps presents out_valid k edges after accept.
  // --------------------------------------------------------------------------
  logic [SW-1:0]  shamt;
  logic [N-1:0]   sh_src;
  logic           sh_left;
  logic [N:0]     sh_step;   // bit N is the bit shifted out
  logic [2*N-1:0] acc_step;

  assign shamt    = B_in[SW-1:0];
  assign sh_src   = (state_q == S_IDLE) ? A_in : sh_q;
  assign sh_left  = (state_q == S_IDLE) ? (alu_op == OP_SHL) : (op_q == OP_SHL);
  assign sh_step  = sh_left ? {sh_src, 1'b0}
                            : {sh_src[0], 1'b0, sh_src[N-1:1]};
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : {(2*N){1'b0}});

  // --------------------------------------------------------------------------
  // Next-state and datapath control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sh_d     = sh_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    load_out = 1'b0;
    fin_res  = alu_out_q;
    fin_c    = carry_q;
    fin_v    = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d = alu_op;
          if ((alu_op == OP_SHL) || (alu_op == OP_SHR)) begin
            if (shamt == '0) begin
              state_d  = S_DONE;
              load_out = 1'b1;
              fin_res  = A_in;
              fin_c    = 1'b0;
              fin_v    = 1'b0;
            end else if (shamt == SW'(1)) begin
              state_d  = S_DONE;
              load_out = 1'b1;
              fin_res  = sh_step[N-1:0];
              fin_c    = sh_step[N];
              fin_v    = 1'b0;
            end else begin
              state_d = S_BUSY;
              sh_d    = sh_step[N-1:0];
              cnt_d   = shamt - SW'(1);
            end
          end else if (alu_op == OP_MUL) begin
            // Bit 0 of the multiplier is handled here; N-1 steps remain.
            state_d  = S_BUSY;
            acc_d    = B_in[0] ? {{N{1'b0}}, A_in} : {(2*N){1'b0}};
            mcand_d  = {{(N-1){1'b0}}, A_in, 1'b0};
            mplier_d = {1'b0, B_in[N-1:1]};
            cnt_d    = SW'(N-1);
          end else begin
            state_d  = S_DONE;
            load_out = 1'b1;
            fin_res  = sc_res;
            fin_c    = sc_c;
            fin_v    = sc_v;
          end
        end
      end

      S_BUSY: begin
        cnt_d = cnt_q - SW'(1);
        if (op_q == OP_MUL) begin
          acc_d    = acc_step;
          mcand_d  = {mcand_q[2*N-2:0], 1'b0};
          mplier_d = {1'b0, mplier_q[N-1:1]};
          if (cnt_q == SW'(1)) begin
            state_d  = S_DONE;
            load_out = 1'b1;
            fin_res  = acc_step[N-1:0];
            fin_c    = |acc_step[2*N-1:N];
            fin_v    = |acc_step[2*N-1:N];
          end
        end else begin
          sh_d = sh_step[N-1:0];
          if (cnt_q == SW'(1)) begin
            state_d  = S_DONE;
            load_out = 1'b1;
            fin_res  = sh_step[N-1:0];
            fin_c    = sh_step[N];
            fin_v    = 1'b0;
          end
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_NOP;
      sh_q      <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      alu_out_q <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      op_q     <= op_d;
      sh_q     <= sh_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      if (load_out) begin
        alu_out_q <= fin_res;
        carry_q   <= fin_c;
        ovf_q     <= fin_v;
        zero_q    <= (fin_res == '0);
        neg_q     <= fin_res[N-1];
      end
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign alu_out   = alu_out_q;
  assign carry_out = carry_q;
  assign zero_flag = zero_q;
  assign neg_flag  = neg_q;
  assign ovf_flag  = ovf_q;

endmodule
`default_nettype wire
